// File: rtl/control_reg_block_if.sv
// Single-word IPbus bus bundle between a bus master and the control register block.
interface control_reg_block_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  ipb_strobe;
  logic                  ipb_write;
  logic [ADDR_WIDTH-1:0] ipb_addr;
  logic [31:0]           ipb_wdata;
  logic [31:0]           ipb_rdata;
  logic                  ipb_ack;
  logic                  ipb_err;

  modport master (
    output ipb_strobe, ipb_write, ipb_addr, ipb_wdata,
    input  ipb_rdata, ipb_ack, ipb_err
  );

  modport slave (
    input  ipb_strobe, ipb_write, ipb_addr, ipb_wdata,
    output ipb_rdata, ipb_ack, ipb_err
  );
endinterface

// File: rtl/control_reg_block.sv
// IPbus control registers: acquisition/trigger settings, shadow/commit thresholds, command pulses.
// Define CTRL_READBACK_EN to enable register readback; otherwise mapped reads return 0.
module control_reg_block #(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned PULSE_LEN       = 4,
  parameter logic [31:0] THRES_DEFAULT   = 32'd1000,
  parameter logic [4:0]  CHAN_EN_DEFAULT = 5'h1F
) (
  input  logic                clk,
  input  logic                reset,
  control_reg_block_if.slave  ipb,
  output logic [4:0]          chan_en,
  output logic                endianness_sel,
  output logic [1:0]          fill_type,
  output logic [4:0]          acq_readout_pause,
  output logic [31:0]         trig_delay,
  output logic [7:0]          trig_settings,
  output logic [31:0]         thres_data_corrupt,
  output logic [31:0]         thres_unknown_ttc,
  output logic [31:0]         thres_ddr3_overflow,
  output logic                clr_err_counts,
  output logic                rst_trig_num,
  output logic                soft_reset
);

  typedef enum logic [1:0] {StIdle, StResp, StRelease} state_e;

  localparam logic [3:0] PulseLoad = 4'(PULSE_LEN);

  state_e      r_state;
  logic        r_ack, r_err;
  logic [31:0] r_rdata;
  logic [4:0]  r_chan_en;
  logic        r_endian;
  logic [1:0]  r_fill;
  logic [4:0]  r_pause;
  logic [31:0] r_trig_delay;
  logic [7:0]  r_trig_set;
  logic [31:0] r_sh_dc, r_sh_ttc, r_sh_ddr;
  logic [31:0] r_th_dc, r_th_ttc, r_th_ddr;
  logic [3:0]  r_cnt_clr, r_cnt_rst, r_cnt_soft;

  logic        w_mapped;
  logic [31:0] w_rdata;

  assign w_mapped = (ipb.ipb_addr <= ADDR_WIDTH'(8));

`ifdef CTRL_READBACK_EN
  logic w_pending;
  assign w_pending = (r_sh_dc != r_th_dc) || (r_sh_ttc != r_th_ttc) || (r_sh_ddr != r_th_ddr);

  always_comb begin
    w_rdata = '0;
    case (ipb.ipb_addr)
      ADDR_WIDTH'(0): w_rdata = {21'd0, r_fill, r_endian, 3'd0, r_chan_en};
      ADDR_WIDTH'(1): w_rdata = r_trig_delay;
      ADDR_WIDTH'(2): w_rdata = {24'd0, r_trig_set};
      ADDR_WIDTH'(3): w_rdata = {27'd0, r_pause};
      ADDR_WIDTH'(4): w_rdata = r_sh_dc;
      ADDR_WIDTH'(5): w_rdata = r_sh_ttc;
      ADDR_WIDTH'(6): w_rdata = r_sh_ddr;
      ADDR_WIDTH'(7): w_rdata = {31'd0, w_pending};
      default:        w_rdata = '0;
    endcase
  end
`else
  assign w_rdata = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_chan_en    <= CHAN_EN_DEFAULT;
      r_endian     <= 1'b0;
      r_fill       <= '0;
      r_pause      <= '0;
      r_trig_delay <= '0;
      r_trig_set   <= '0;
      r_sh_dc      <= THRES_DEFAULT;
      r_sh_ttc     <= THRES_DEFAULT;
      r_sh_ddr     <= THRES_DEFAULT;
      r_th_dc      <= THRES_DEFAULT;
      r_th_ttc     <= THRES_DEFAULT;
      r_th_ddr     <= THRES_DEFAULT;
      r_cnt_clr    <= '0;
      r_cnt_rst    <= '0;
      r_cnt_soft   <= '0;
    end else begin
      // Free-running countdown; a command write below overrides it with a reload.
      if (r_cnt_clr  != 4'd0) r_cnt_clr  <= r_cnt_clr  - 4'd1;
      if (r_cnt_rst  != 4'd0) r_cnt_rst  <= r_cnt_rst  - 4'd1;
      if (r_cnt_soft != 4'd0) r_cnt_soft <= r_cnt_soft - 4'd1;

      case (r_state)
        StIdle: begin
          if (ipb.ipb_strobe) begin
            r_state <= StResp;
            r_ack   <= w_mapped;
            r_err   <= !w_mapped;
            r_rdata <= w_rdata;
            if (ipb.ipb_write) begin
              case (ipb.ipb_addr)
                ADDR_WIDTH'(0): begin
                  r_chan_en <= ipb.ipb_wdata[4:0];
                  r_endian  <= ipb.ipb_wdata[8];
                  r_fill    <= ipb.ipb_wdata[10:9];
                end
                ADDR_WIDTH'(1): r_trig_delay <= ipb.ipb_wdata;
                ADDR_WIDTH'(2): r_trig_set   <= ipb.ipb_wdata[7:0];
                ADDR_WIDTH'(3): r_pause      <= ipb.ipb_wdata[4:0];
                ADDR_WIDTH'(4): r_sh_dc      <= ipb.ipb_wdata;
                ADDR_WIDTH'(5): r_sh_ttc     <= ipb.ipb_wdata;
                ADDR_WIDTH'(6): r_sh_ddr     <= ipb.ipb_wdata;
                ADDR_WIDTH'(7): begin
                  if (ipb.ipb_wdata[0]) begin
                    r_th_dc  <= r_sh_dc;
                    r_th_ttc <= r_sh_ttc;
                    r_th_ddr <= r_sh_ddr;
                  end
                end
                ADDR_WIDTH'(8): begin
                  if (ipb.ipb_wdata[0]) r_cnt_clr  <= PulseLoad;
                  if (ipb.ipb_wdata[1]) r_cnt_rst  <= PulseLoad;
                  if (ipb.ipb_wdata[2]) r_cnt_soft <= PulseLoad;
                end
                default: ;
              endcase
            end
          end
        end
        StResp: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= StRelease;
        end
        StRelease: begin
          if (!ipb.ipb_strobe) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ipb.ipb_ack   = r_ack;
  assign ipb.ipb_err   = r_err;
  assign ipb.ipb_rdata = r_rdata;

  assign chan_en             = r_chan_en;
  assign endianness_sel      = r_endian;
  assign fill_type           = r_fill;
  assign acq_readout_pause   = r_pause;
  assign trig_delay          = r_trig_delay;
  assign trig_settings       = r_trig_set;
  assign thres_data_corrupt  = r_th_dc;
  assign thres_unknown_ttc   = r_th_ttc;
  assign thres_ddr3_overflow = r_th_ddr;
  assign clr_err_counts      = (r_cnt_clr  != 4'd0);
  assign rst_trig_num        = (r_cnt_rst  != 4'd0);
  assign soft_reset          = (r_cnt_soft != 4'd0);

endmodule

// File: tb/tb_control_reg_block.sv
// Directed self-checking bench for control_reg_block (readback expectations follow CTRL_READBACK_EN).
module tb_control_reg_block;

`ifdef CTRL_READBACK_EN
  localparam bit Rb = 1'b1;
`else
  localparam bit Rb = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  chan_en;
  logic        endianness_sel;
  logic [1:0]  fill_type;
  logic [4:0]  acq_readout_pause;
  logic [31:0] trig_delay;
  logic [7:0]  trig_settings;
  logic [31:0] thres_data_corrupt, thres_unknown_ttc, thres_ddr3_overflow;
  logic        clr_err_counts, rst_trig_num, soft_reset;

  int total = 0;
  int bad   = 0;

  control_reg_block_if #(.ADDR_WIDTH(5)) ipb_if ();

  control_reg_block dut (
    .clk                 (clk),
    .reset               (reset),
    .ipb                 (ipb_if),
    .chan_en             (chan_en),
    .endianness_sel      (endianness_sel),
    .fill_type           (fill_type),
    .acq_readout_pause   (acq_readout_pause),
    .trig_delay          (trig_delay),
    .trig_settings       (trig_settings),
    .thres_data_corrupt  (thres_data_corrupt),
    .thres_unknown_ttc   (thres_unknown_ttc),
    .thres_ddr3_overflow (thres_ddr3_overflow),
    .clr_err_counts      (clr_err_counts),
    .rst_trig_num        (rst_trig_num),
    .soft_reset          (soft_reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept edge, ack cycle, then release back to idle.
  task automatic bus(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic ack, output logic err,
                     output logic ack_after);
    ipb_if.ipb_strobe = 1'b1;
    ipb_if.ipb_write  = wr;
    ipb_if.ipb_addr   = addr;
    ipb_if.ipb_wdata  = wd;
    @(posedge clk); #1;
    rd  = ipb_if.ipb_rdata;
    ack = ipb_if.ipb_ack;
    err = ipb_if.ipb_err;
    ipb_if.ipb_strobe = 1'b0;
    @(posedge clk); #1;
    ack_after = ipb_if.ipb_ack | ipb_if.ipb_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        ack, err, ack_after;
  int          acks;

  initial begin
    reset = 1'b0;
    ipb_if.ipb_strobe = 1'b0;
    ipb_if.ipb_write  = 1'b0;
    ipb_if.ipb_addr   = '0;
    ipb_if.ipb_wdata  = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    chk("rst_chan_en", chan_en, 32'h1F);
    chk("rst_thres_dc", thres_data_corrupt, 32'd1000);
    chk("rst_thres_ttc", thres_unknown_ttc, 32'd1000);
    chk("rst_thres_ddr", thres_ddr3_overflow, 32'd1000);
    chk("rst_trig_delay", trig_delay, 32'd0);
    chk("rst_pulses", {clr_err_counts, rst_trig_num, soft_reset}, 32'd0);
    chk("rst_ack_err", {ipb_if.ipb_ack, ipb_if.ipb_err}, 32'd0);

    bus(1'b1, 5'h01, 32'h0000_0123, rd, ack, err, ack_after);
    chk("wr01_ack", ack, 32'd1);
    chk("wr01_err", err, 32'd0);
    chk("wr01_ack_one_cycle", ack_after, 32'd0);
    chk("wr01_trig_delay", trig_delay, 32'h123);
    bus(1'b0, 5'h01, 32'hFFFF_FFFF, rd, ack, err, ack_after);
    chk("rd01_ack", ack, 32'd1);
    chk("rd01_data", rd, Rb ? 32'h123 : 32'h0);

    bus(1'b1, 5'h00, 32'hFFFF_FD15, rd, ack, err, ack_after);
    chk("wr00_chan_en", chan_en, 32'h15);
    chk("wr00_endian", endianness_sel, 32'd1);
    chk("wr00_fill", fill_type, 32'd2);
    bus(1'b0, 5'h00, 32'h0, rd, ack, err, ack_after);
    chk("rd00_data", rd, Rb ? 32'h515 : 32'h0);

    bus(1'b1, 5'h02, 32'hABCD_1234, rd, ack, err, ack_after);
    chk("wr02_trig_set", trig_settings, 32'h34);
    bus(1'b1, 5'h03, 32'hFFFF_FFE7, rd, ack, err, ack_after);
    chk("wr03_pause", acq_readout_pause, 32'h07);
    bus(1'b0, 5'h03, 32'h0, rd, ack, err, ack_after);
    chk("rd03_data", rd, Rb ? 32'h07 : 32'h0);

    bus(1'b1, 5'h04, 32'd500, rd, ack, err, ack_after);
    bus(1'b0, 5'h07, 32'h0, rd, ack, err, ack_after);
    chk("pending_set", rd, Rb ? 32'd1 : 32'd0);
    chk("dc_not_committed", thres_data_corrupt, 32'd1000);
    bus(1'b1, 5'h07, 32'd1, rd, ack, err, ack_after);
    chk("dc_committed", thres_data_corrupt, 32'd500);
    chk("ttc_unchanged", thres_unknown_ttc, 32'd1000);
    bus(1'b0, 5'h07, 32'h0, rd, ack, err, ack_after);
    chk("pending_clear", rd, 32'd0);
    bus(1'b1, 5'h05, 32'd77, rd, ack, err, ack_after);
    bus(1'b1, 5'h07, 32'd2, rd, ack, err, ack_after);
    chk("commit_bit0_zero", thres_unknown_ttc, 32'd1000);
    bus(1'b0, 5'h05, 32'h0, rd, ack, err, ack_after);
    chk("rd05_shadow", rd, Rb ? 32'd77 : 32'd0);
    bus(1'b1, 5'h07, 32'd1, rd, ack, err, ack_after);
    chk("ttc_committed", thres_unknown_ttc, 32'd77);
    chk("ddr_default", thres_ddr3_overflow, 32'd1000);

    // Command pulses: 0b101, then bit0 rewritten while the pulse is still running.
    ipb_if.ipb_strobe = 1'b1;
    ipb_if.ipb_write  = 1'b1;
    ipb_if.ipb_addr   = 5'h08;
    ipb_if.ipb_wdata  = 32'h5;
    @(posedge clk); #1;
    chk("cmd_clr_k0", clr_err_counts, 32'd1);
    chk("cmd_soft_k0", soft_reset, 32'd1);
    chk("cmd_rst_k0", rst_trig_num, 32'd0);
    ipb_if.ipb_strobe = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("cmd_clr_k%0d", k), clr_err_counts, (k <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("cmd_soft_k%0d", k), soft_reset, (k <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("cmd_rst_k%0d", k), rst_trig_num, 32'd0);
      if (k == 2) begin
        ipb_if.ipb_strobe = 1'b1;
        ipb_if.ipb_wdata  = 32'h1;
      end
      if (k == 3) begin
        chk("cmd_rewrite_ack", ipb_if.ipb_ack, 32'd1);
        ipb_if.ipb_strobe = 1'b0;
      end
    end
    bus(1'b0, 5'h08, 32'h0, rd, ack, err, ack_after);
    chk("rd08_ack", ack, 32'd1);
    chk("rd08_zero", rd, 32'd0);

    bus(1'b1, 5'h15, 32'h0000_DEAD, rd, ack, err, ack_after);
    chk("unmapped_err", err, 32'd1);
    chk("unmapped_ack", ack, 32'd0);
    chk("unmapped_err_one_cycle", ack_after, 32'd0);
    chk("unmapped_no_change", trig_delay, 32'h123);
    bus(1'b1, 5'h09, 32'h0000_0007, rd, ack, err, ack_after);
    chk("unmapped09_err", err, 32'd1);
    chk("unmapped09_no_pulse", {clr_err_counts, rst_trig_num, soft_reset}, 32'd0);
    bus(1'b0, 5'h15, 32'h0, rd, ack, err, ack_after);
    chk("unmapped_rd_zero", rd, 32'd0);

    ipb_if.ipb_strobe = 1'b1;
    ipb_if.ipb_write  = 1'b0;
    ipb_if.ipb_addr   = 5'h01;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ipb_if.ipb_ack) acks++;
    end
    chk("held_strobe_one_ack", acks, 32'd1);
    ipb_if.ipb_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the ack cycle with strobe still high.
    ipb_if.ipb_strobe = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_ack", ipb_if.ipb_ack, 32'd1);
    reset = 1'b0;
    #1;
    chk("reset_ack_drop", ipb_if.ipb_ack, 32'd0);
    chk("reset_trig_delay", trig_delay, 32'd0);
    chk("reset_chan_en", chan_en, 32'h1F);
    chk("reset_thres_dc", thres_data_corrupt, 32'd1000);
    chk("reset_thres_ttc", thres_unknown_ttc, 32'd1000);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_accept", ipb_if.ipb_ack, 32'd1);
    chk("post_reset_rdata", ipb_if.ipb_rdata, 32'd0);
    ipb_if.ipb_strobe = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_reg_block.md
Name: control_reg_block

Overview:
- IPbus write-side counterpart of the Rider status register block: holds the user-writable control registers that drive the acquisition, trigger and error-threshold logic.
- Accepts single-word IPbus transactions through an ack-based handshake and supports register readback.
- Applies the three soft-error thresholds atomically through a shadow/commit scheme.
- Generates fixed-length command pulses for counter clears and soft resets.

Parameters:
ADDR_WIDTH, 5, IPbus word-address width
PULSE_LEN, 4, cycles each command pulse stays high (1..15)
THRES_DEFAULT, 32'd1000, reset value of all three thresholds (shadow and active)
CHAN_EN_DEFAULT, 5'h1F, reset value of chan_en

Ports:
clk  in  1  user interface clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
ipb_strobe  in  1  transaction request; held high until ack/err is seen
ipb_write  in  1  1 = write, 0 = read; valid while ipb_strobe is high
ipb_addr  in  ADDR_WIDTH  word address; valid while ipb_strobe is high
ipb_wdata  in  32  write data; valid while ipb_strobe is high
ipb_rdata  out  32  read data; valid in the ack cycle
ipb_ack  out  1  one-cycle transaction-complete pulse
ipb_err  out  1  one-cycle error pulse for an unmapped address
chan_en  out  5  channel enables
endianness_sel  out  1  output endianness select
fill_type  out  2  fill type
acq_readout_pause  out  5  readout pause
trig_delay  out  32  trigger delay
trig_settings  out  8  trigger settings
thres_data_corrupt  out  32  active data-corruption threshold
thres_unknown_ttc  out  32  active unknown-TTC threshold
thres_ddr3_overflow  out  32  active DDR3-overflow threshold
clr_err_counts  out  1  command pulse: clear the soft-error counters
rst_trig_num  out  1  command pulse: reset the trigger number
soft_reset  out  1  command pulse: soft reset of the acquisition logic

Behaviour:
Register map, by word address:
- 0x00: [4:0] chan_en, [8] endianness_sel, [10:9] fill_type. Other bits read 0.
- 0x01: trig_delay.
- 0x02: [7:0] trig_settings.
- 0x03: [4:0] acq_readout_pause.
- 0x04..0x06: shadow thresholds for data_corrupt, unknown_ttc and ddr3_overflow respectively.
- 0x07: commit. Write with wdata[0]=1 copies all three shadows to the active threshold outputs on the same edge. Reads return {31'd0, pending}; pending=1 when any shadow differs from its active value.
- 0x08: command register, write-only, reads 0. wdata bit0 -> clr_err_counts, bit1 -> rst_trig_num, bit2 -> soft_reset.
- Addresses 0x09 and above are unmapped.

Handshake FSM (IDLE, RESP, RELEASE):
- IDLE: when ipb_strobe=1 at a rising edge, the write (if any) is performed on that edge and the FSM moves to RESP.
- RESP: exactly one cycle. ipb_ack=1, or ipb_err=1 for an unmapped address. ipb_rdata holds the value registered at the accept edge; for reads of an unmapped address it is 0. Next state is RELEASE.
- RELEASE: wait for ipb_strobe=0, then return to IDLE. A strobe held high never produces a second transaction.
- Latency: the ack appears exactly 1 cycle after the accept edge.
- Unmapped writes change no state.
- Partial-width fields take the low bits of ipb_wdata; upper bits are ignored.

Command pulses:
- A write to 0x08 with a bit set loads that bit's 4-bit counter with PULSE_LEN.
- The output is high while its counter is nonzero; the counter decrements by 1 each cycle.
- The pulse goes high on the cycle after the accept edge and lasts exactly PULSE_LEN cycles.
- A rewrite while the pulse is active reloads the counter, extending the pulse with no gap.
- Bits cleared in wdata leave their counters untouched.

Reset (asynchronous, any time including mid-transaction):
- Outputs: chan_en=CHAN_EN_DEFAULT, all thresholds and shadows = THRES_DEFAULT, every other output 0.
- Internal: FSM returns to IDLE and all pulse counters clear.
- After reset is released, a strobe that is still high is accepted as a new transaction.

Optional Feature:
CTRL_READBACK_EN
- Defined: reads return the register contents as mapped above.
- Undefined: reads of mapped addresses return 0 with a normal ack; readback muxing is removed. Writes, err behaviour and timing are unchanged.

Test Plan:
- Reset release -> chan_en=5'h1F, thresholds=1000, all pulses 0, ack=0, err=0.
- Write 0x01 with 32'h0000_0123 -> trig_delay=0x123 on the accept edge; ack high exactly 1 cycle later; read 0x01 returns 0x123 (CTRL_READBACK_EN defined).
- Write 0x04=500, then read 0x07 -> returns 1 while thres_data_corrupt is still 1000. Write 0x07=1 -> thres_data_corrupt=500, and a subsequent read of 0x07 returns 0.
- Write 0x08=3'b101 -> clr_err_counts and soft_reset high for exactly 4 cycles, rst_trig_num stays 0. Rewrite bit0 in cycle 2 of the pulse -> clr_err_counts is extended to 4 cycles after the second write.
- Access 0x15 -> err=1 for one cycle, ack=0, no register changes. A strobe held high for 10 cycles -> exactly one ack.
- Assert reset during RESP with trig_delay=0x123 -> ack drops immediately, trig_delay=0, FSM in IDLE.
